// File: rtl/mvm_pkg.sv
// Shared sizing helpers and the round-half-up / saturate step for the dot-product engine.
// Purely constant/combinational functions; no latency and no flow control of their own.
package mvm_pkg;

   typedef struct packed {
      logic signed [31:0] data;
      logic               sat;
   } round_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int acc_width(input int data_width, input int lanes, input int max_beats);
      return 2 * data_width + clog2(lanes) + clog2(max_beats);
   endfunction

   // Accumulator arrives sign-extended to 64 bits so the rounding add can never overflow.
   function automatic round_t round_sat(input logic signed [63:0] acc,
                                        input int frac_shift,
                                        input int data_width);
      logic signed [63:0] r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      round_t             res;
      r        = (acc + (64'sd1 <<< (frac_shift - 1))) >>> frac_shift;
      hi       = (64'sd1 <<< (data_width - 1)) - 64'sd1;
      lo       = -(64'sd1 <<< (data_width - 1));
      res.data = r[31:0];
      res.sat  = 1'b0;
      if (r > hi) begin
         res.data = hi[31:0];
         res.sat  = 1'b1;
      end else if (r < lo) begin
         res.data = lo[31:0];
         res.sat  = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/signed_dot_lanes.sv
// LANES signed multipliers and a sign-extending sum of already-registered products.
// Combinational, zero latency; no flow control, the caller registers between the two halves.
module signed_dot_lanes
   import mvm_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 4
) (
   input  logic        [LANES*DATA_WIDTH-1:0]              w,
   input  logic        [LANES*DATA_WIDTH-1:0]              x,
   output logic        [LANES*2*DATA_WIDTH-1:0]            prod,
   input  logic        [LANES*2*DATA_WIDTH-1:0]            prod_in,
   output logic signed [2*DATA_WIDTH+clog2(LANES)-1:0]     sum
);

   localparam int PW    = 2 * DATA_WIDTH;
   localparam int SUM_W = PW + clog2(LANES);

   function automatic logic signed [PW-1:0] smul(input logic signed [DATA_WIDTH-1:0] a,
                                                 input logic signed [DATA_WIDTH-1:0] b);
      return PW'(a) * PW'(b);
   endfunction

   always_comb begin
      prod = '0;
      for (int i = 0; i < LANES; i++) begin
         prod[i*PW +: PW] = smul(w[i*DATA_WIDTH +: DATA_WIDTH], x[i*DATA_WIDTH +: DATA_WIDTH]);
      end
   end

   always_comb begin
      sum = '0;
      for (int i = 0; i < LANES; i++) begin
         sum = sum + SUM_W'($signed(prod_in[i*PW +: PW]));
      end
   end

endmodule

// File: rtl/mvm_seq_accum.sv
// Streaming signed dot-product: products registered, rows accumulated, then rounded/saturated out.
// Last beat to out_valid is two edges; a held result (out_valid & ~out_ready) freezes both stages and drops in_ready.
module mvm_seq_accum
   import mvm_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 4,
   parameter int MAX_BEATS  = 16,
   parameter int FRAC_SHIFT = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [LANES*DATA_WIDTH-1:0]        in_w,
   input  logic [LANES*DATA_WIDTH-1:0]        in_x,
   input  logic                               in_last,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [DATA_WIDTH-1:0]              out_data,
   output logic                               out_sat,
   output logic                               out_err,
   output logic [clog2(MAX_BEATS+1)-1:0]      out_beats
);

   localparam int PW     = 2 * DATA_WIDTH;
   localparam int SUM_W  = PW + clog2(LANES);
   localparam int ACC_W  = acc_width(DATA_WIDTH, LANES, MAX_BEATS);
   localparam int BEAT_W = clog2(MAX_BEATS + 1);

   typedef struct packed {
      logic                  last;
      logic [LANES*PW-1:0]   prod;
   } pstage_t;

   logic                     stall;
   logic                     in_xfer;
   logic                     a_fire;
   logic [LANES*PW-1:0]      prod_comb;
   logic signed [SUM_W-1:0]  beat_sum;

   pstage_t                  p_q;
   logic                     p_valid;

   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  acc_base;
   logic signed [ACC_W-1:0]  acc_next;
   logic                     row_start;
   logic [BEAT_W-1:0]        beat_cnt;
   logic [BEAT_W-1:0]        cnt_next;
   logic                     row_err;
   logic                     err_next;
   round_t                   rs;
   logic                     unused_rs_hi;

   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;
   assign in_xfer  = in_valid & in_ready;
   assign a_fire   = p_valid & ~stall;

   signed_dot_lanes #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (LANES)
   ) u_dot (
      .w       (in_w),
      .x       (in_x),
      .prod    (prod_comb),
      .prod_in (p_q.prod),
      .sum     (beat_sum)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         p_valid <= 1'b0;
         p_q     <= '0;
      end else if (!stall) begin
         p_valid <= in_xfer;
         if (in_xfer) begin
            p_q.prod <= prod_comb;
            p_q.last <= in_last;
         end
      end
   end

   // Past MAX_BEATS the count sticks, the error latches and the sum is allowed to wrap.
   always_comb begin
      acc_base = row_start ? '0 : acc;
      acc_next = acc_base + ACC_W'(beat_sum);
      cnt_next = beat_cnt;
      err_next = row_err;
      if (beat_cnt == BEAT_W'(MAX_BEATS)) begin
         err_next = 1'b1;
      end else begin
         cnt_next = beat_cnt + BEAT_W'(1);
      end
      rs = round_sat(64'(acc_next), FRAC_SHIFT, DATA_WIDTH);
   end

   assign unused_rs_hi = ^rs.data[31:DATA_WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         row_start <= 1'b1;
         beat_cnt  <= '0;
         row_err   <= 1'b0;
      end else if (a_fire) begin
         if (p_q.last) begin
            acc       <= '0;
            row_start <= 1'b1;
            beat_cnt  <= '0;
            row_err   <= 1'b0;
         end else begin
            acc       <= acc_next;
            row_start <= 1'b0;
            beat_cnt  <= cnt_next;
            row_err   <= err_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
         out_err   <= 1'b0;
         out_beats <= '0;
      end else if (a_fire && p_q.last) begin
         out_valid <= 1'b1;
         out_data  <= rs.data[DATA_WIDTH-1:0];
         out_sat   <= rs.sat;
         out_err   <= err_next;
         out_beats <= cnt_next;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
